// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// uart_rx_param : 16x-oversampled UART receiver with a run-time baud divisor.
// Optional parity checker: define UART_RX_PARITY_EN.            Rev 1.0
// ============================================================================
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 1,
  parameter int DIV_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [3:0]       LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = (PARITY_MODE != 0);
`else
  // No parity bit on the line whatever the mode says.
  localparam logic PAR_EN = 1'b0 && (PARITY_MODE != 0);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nx;
  logic                 rx_meta, rx_s;
  logic [DIV_W-1:0]     div_q, tick_cnt;
  logic [3:0]           os_cnt, bit_idx;
  logic                 stop_idx, stop_bad;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, sample, frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick       = (state != IDLE) && (tick_cnt == div_q - DIV_ONE);
  assign sample     = tick && (os_cnt == 4'd7);
  assign frame_done = (state == STOP) && sample && (stop_idx == LAST_STOP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!rx_s) state_nx = START;
      START:   if (sample) state_nx = rx_s ? IDLE : DATA;
      DATA:    if (sample && bit_idx == LAST_BIT) state_nx = PAR_EN ? PARITY : STOP;
      PARITY:  if (sample) state_nx = STOP;
      STOP:    if (frame_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // os_cnt keeps counting through START, so the 8th-tick start check leaves
  // every later os_cnt==7 tick exactly at mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= DIV_ONE;
      tick_cnt   <= '0;
      os_cnt     <= 4'd0;
      bit_idx    <= 4'd0;
      stop_idx   <= 1'b0;
      stop_bad   <= 1'b0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (state == IDLE) begin
        tick_cnt <= '0;
        os_cnt   <= 4'd0;
        bit_idx  <= 4'd0;
        stop_idx <= 1'b0;
        stop_bad <= 1'b0;
        if (!rx_s) div_q <= (baud_div == '0) ? DIV_ONE : baud_div;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + DIV_ONE;
        if (tick) os_cnt <= os_cnt + 4'd1;
        if (sample && state == DATA) begin
          shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + 4'd1;
        end
        if (sample && state == STOP) begin
          stop_idx <= ~stop_idx;
          if (!rx_s) stop_bad <= 1'b1;
        end
      end
      if (frame_done) begin
        data_out   <= shreg;
        frame_err  <= stop_bad | ~rx_s;
        data_valid <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == IDLE)
        par_bad <= 1'b0;
      else if (sample && state == PARITY)
        par_bad <= (PARITY_MODE == 2) ? (^shreg ^ rx_s) : ~(^shreg ^ rx_s);
      if (frame_done) parity_err <= par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_param : table-driven, directed and random frames for uart_rx_param.
// ============================================================================
module tb_uart_rx_param;
  localparam int DATA_BITS   = 8;
  localparam int STOP_BITS   = 1;
  localparam int PARITY_MODE = 1;
  localparam int DIV_W       = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int NBITS = 1 + DATA_BITS + int'(PAR_ON) + STOP_BITS;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] baud_div = 16'd4;
  logic             rx = 1'b1;
  logic [7:0]       data_out;
  logic             data_valid, parity_err, frame_err, busy;

  int errors = 0;
  int checks = 0;

  time        ev_t[$];
  logic [7:0] ev_d[$];
  logic       ev_p[$];
  logic       ev_f[$];
  int         wide = 0;
  logic       prev_v = 1'b0;

  typedef struct {
    logic [7:0] d;
    bit         pbad;
    bit         sbad;
    int         div;
    logic [7:0] exp_d;
    bit         exp_pe;
    bit         exp_fe;
  } vec_t;

  always #5 clk = ~clk;

  uart_rx_param #(
    .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS),
    .PARITY_MODE(PARITY_MODE), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (data_valid) begin
        ev_t.push_back($time);
        ev_d.push_back(data_out);
        ev_p.push_back(parity_err);
        ev_f.push_back(frame_err);
        if (prev_v) wide++;
      end
      prev_v = data_valid;
    end
  end

  function automatic int eff(input int div);
    return (div == 0) ? 1 : div;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drives one frame starting at the current negedge; baud_div is scrambled
  // during the payload to show the divisor is held for the whole frame.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopv,
                            input int div, output time t0);
    logic bits[$];
    int   e;
    e = eff(div);
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
    if (PAR_ON) bits.push_back(pbit);
    for (int s = 0; s < STOP_BITS; s++) bits.push_back((s == STOP_BITS - 1) ? stopv : 1'b1);
    baud_div = DIV_W'(div);
    t0 = $time;
    foreach (bits[i]) begin
      if (i == 1) baud_div = DIV_W'($urandom);
      if (i == 1 + DATA_BITS + int'(PAR_ON)) baud_div = DIV_W'(div);
      rx = bits[i];
      repeat (16 * e) @(negedge clk);
    end
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] d, input bit pe, input bit fe,
                              input time t0, input int e, output time tv);
    int n;
    int lat;
    int k;
    n  = 0;
    tv = 0;
    while (ev_t.size() == 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " valid seen"}, ev_t.size() != 0, 1);
    if (ev_t.size() != 0) begin
      tv = ev_t.pop_front();
      chk({nm, " data"}, ev_d.pop_front(), d);
      chk({nm, " parity_err"}, ev_p.pop_front(), pe);
      chk({nm, " frame_err"}, ev_f.pop_front(), fe);
      // Last stop sample sits 8 + 16*(NBITS-1) ticks after the start edge,
      // plus the synchroniser and output register.
      k   = (8 + 16 * (NBITS - 1)) * e;
      lat = int'((tv - t0) / 10);
      checks++;
      if (lat < k + 2 || lat > k + 4) begin
        errors++;
        $display("FAIL %s latency: got %0d clk expected %0d..%0d", nm, lat, k + 2, k + 4);
      end
    end
  endtask

  initial begin : stim
    vec_t       tbl[8];
    time        t0, t1, tv0, tv1;
    logic [7:0] d, v99;
    logic       pbit, pbad, sbad;
    int         div, gap;
    bit         exp_pe;

    tbl[0] = '{8'hA5, 1'b0, 1'b0, 4, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 4, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 4, 8'h3C, PAR_ON, 1'b0};
    tbl[3] = '{8'h55, 1'b0, 1'b1, 4, 8'h55, 1'b0, 1'b1};
    tbl[4] = '{8'h0F, 1'b0, 1'b0, 4, 8'h0F, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 1, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 1'b1, 1'b1, 2, 8'hFF, PAR_ON, 1'b1};
    tbl[7] = '{8'h80, 1'b0, 1'b0, 0, 8'h80, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset data_out", data_out, 0);
    chk("reset data_valid", data_valid, 0);
    chk("reset parity_err", parity_err, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].d, (~^tbl[i].d) ^ tbl[i].pbad, ~tbl[i].sbad, tbl[i].div, t0);
      rx = 1'b1;
      repeat (32 * eff(tbl[i].div)) @(negedge clk);
      expect_frame($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe,
                   t0, eff(tbl[i].div), tv0);
      chk($sformatf("vec%0d busy idle", i), busy, 0);
    end

    // Start-bit glitches shorter than half a bit are rejected.
    baud_div = 16'd4;
    for (int g = 0; g < 2; g++) begin
      rx = 1'b0;
      repeat (5) @(negedge clk);
      chk("glitch busy high", busy, 1);
      repeat ((g == 0) ? 7 : 19) @(negedge clk);
      rx = 1'b1;
      repeat (128) @(negedge clk);
      chk("glitch busy low", busy, 0);
      chk("glitch no valid", ev_t.size(), 0);
    end

    // Back-to-back frames with no idle gap.
    send_frame(8'h01, ~^8'h01, 1'b1, 4, t0);
    send_frame(8'hFE, ~^8'hFE, 1'b1, 4, t1);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    expect_frame("b2b first", 8'h01, 1'b0, 1'b0, t0, 4, tv0);
    expect_frame("b2b second", 8'hFE, 1'b0, 1'b0, t1, 4, tv1);
    chk("b2b spacing", int'((tv1 - tv0) / 10), 16 * 4 * NBITS);

    // Reset in the middle of data bit 4.
    v99 = 8'h99;
    baud_div = 16'd4;
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      rx = v99[j];
      repeat (64) @(negedge clk);
    end
    rx = v99[4];
    repeat (32) @(negedge clk);
    chk("pre-reset busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset data_out", data_out, 0);
    chk("midreset parity_err", parity_err, 0);
    chk("midreset frame_err", frame_err, 0);
    chk("midreset busy", busy, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("midreset no valid", ev_t.size(), 0);
    send_frame(8'h12, ~^8'h12, 1'b1, 4, t0);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    expect_frame("after reset", 8'h12, 1'b0, 1'b0, t0, 4, tv0);

    // Random frames against the frame-level reference model.
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      pbad = ($urandom_range(0, 3) == 0);
      sbad = ($urandom_range(0, 3) == 0);
      div  = $urandom_range(0, 3);
      pbit = (~^d) ^ pbad;
      send_frame(d, pbit, ~sbad, div, t0);
      gap = sbad ? $urandom_range(2, 3) : $urandom_range(0, 2);
      rx = 1'b1;
      repeat (gap * 16 * eff(div)) @(negedge clk);
      if (PARITY_MODE == 2) exp_pe = PAR_ON && (^{d, pbit});
      else                  exp_pe = PAR_ON && (PARITY_MODE == 1) && !(^{d, pbit});
      expect_frame($sformatf("rand%0d", n), d, exp_pe, sbad, t0, eff(div), tv0);
      if (gap != 0) chk($sformatf("rand%0d busy idle", n), busy, 0);
    end

    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("no stray valid", ev_t.size(), 0);
    chk("valid width", wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
